// File: rtl/alarm_clock_pkg.sv
// Shared types, BCD limits and BCD helpers for the alarm clock time-of-day keeper.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam logic [7:0] MAX_HH_BCD = 8'h23;
  localparam logic [7:0] MAX_MM_BCD = 8'h59;

  function automatic logic bcd_valid(input logic [7:0] hh, input logic [7:0] mm);
    return (hh[7:4] <= 4'd9) && (hh[3:0] <= 4'd9) &&
           (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9) &&
           (hh <= MAX_HH_BCD) && (mm <= MAX_MM_BCD);
  endfunction

  // Two-digit BCD increment that wraps to 00 after reaching max_bcd.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_bcd);
    if (v == max_bcd)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD_BCD; load has priority over inc, carry marks the wrap.
module bcd_mod_counter
  import alarm_clock_pkg::*;
#(
  parameter logic [7:0] MOD_BCD = 8'h59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic       o_carry
);

  logic [7:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_count <= 8'h00;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_inc)
      r_count <= bcd_inc(r_count, MOD_BCD);
  end

  assign o_count = r_count;
  assign o_carry = i_inc & (r_count == MOD_BCD);

endmodule

// File: rtl/time_of_day_keeper.sv
// BCD HH:MM time of day, programmable alarm and IDLE/RINGING/SNOOZE alarm FSM with 1 Hz buzzer.
// Define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise the snooze input is ignored.
module time_of_day_keeper
  import alarm_clock_pkg::*;
#(
  parameter int unsigned RING_MINUTES   = 5,
  parameter int unsigned SNOOZE_MINUTES = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       load_time,
  input  logic       load_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       alarm_en,
  input  logic       stop_alarm,
  input  logic       snooze,
  output logic [7:0] time_hh,
  output logic [7:0] time_mm,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       ringing,
  output logic       buzzer,
  output logic       load_err,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_RING   = 2'(RINGING);
  localparam logic [3:0] RING_LIM = 4'(RING_MINUTES);

  logic       w_set_ok, w_ld_time, w_ld_alarm;
  logic       w_min_inc, w_min_carry, w_match;
  logic [7:0] w_next_hh, w_next_mm;
  logic [3:0] w_ring_nxt;
  logic [7:0] r_alarm_hh, r_alarm_mm;
  logic       r_load_err, r_phase;
  logic [1:0] r_state;
  logic [3:0] r_ring_cnt;

  assign w_set_ok   = bcd_valid(set_hh, set_mm);
  assign w_ld_time  = load_time & w_set_ok;
  assign w_ld_alarm = load_alarm & w_set_ok;
  // A load_time strobe always swallows a coincident minute pulse, valid or not.
  assign w_min_inc  = one_minute & ~load_time;

  bcd_mod_counter #(.MOD_BCD(MAX_MM_BCD)) u_min (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (w_min_inc),
    .i_load     (w_ld_time),
    .i_load_val (set_mm),
    .o_count    (time_mm),
    .o_carry    (w_min_carry)
  );

  bcd_mod_counter #(.MOD_BCD(MAX_HH_BCD)) u_hr (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (w_min_carry),
    .i_load     (w_ld_time),
    .i_load_val (set_hh),
    .o_count    (time_hh),
    .o_carry    ()
  );

  // Match compares the time this minute pulse produces against the pre-edge alarm.
  assign w_next_mm = bcd_inc(time_mm, MAX_MM_BCD);
  assign w_next_hh = (time_mm == MAX_MM_BCD) ? bcd_inc(time_hh, MAX_HH_BCD) : time_hh;
  assign w_match   = w_min_inc & alarm_en & ({w_next_hh, w_next_mm} == {r_alarm_hh, r_alarm_mm});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alarm_hh <= 8'h00;
      r_alarm_mm <= 8'h00;
      r_load_err <= 1'b0;
    end else begin
      if (w_ld_alarm) begin
        r_alarm_hh <= set_hh;
        r_alarm_mm <= set_mm;
      end
      r_load_err <= (load_time | load_alarm) & ~w_set_ok;
    end
  end

  assign w_ring_nxt = (r_ring_cnt == 4'hF) ? r_ring_cnt : r_ring_cnt + 4'd1;

`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] S_SNOOZE = 2'(SNOOZE);
  localparam logic [3:0] SNZ_LIM  = 4'(SNOOZE_MINUTES);
  logic [3:0] r_snz_cnt;
  logic [3:0] w_snz_nxt;
  assign w_snz_nxt = (r_snz_cnt == 4'hF) ? r_snz_cnt : r_snz_cnt + 4'd1;
`else
  logic w_unused;
  assign w_unused = ^{snooze, SNOOZE_MINUTES};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ring_cnt <= 4'd0;
      r_phase    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt  <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_match) begin
            r_state    <= S_RING;
            r_ring_cnt <= 4'd0;
            r_phase    <= 1'b1;
          end
        end
        S_RING: begin
          if (one_second)
            r_phase <= ~r_phase;
          if (stop_alarm || !alarm_en)
            r_state <= S_IDLE;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin
            r_state   <= S_SNOOZE;
            r_snz_cnt <= 4'd0;
          end
`endif
          else if (one_minute) begin
            r_ring_cnt <= w_ring_nxt;
            if (w_ring_nxt >= RING_LIM)
              r_state <= S_IDLE;
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (stop_alarm || !alarm_en)
            r_state <= S_IDLE;
          else if (one_minute) begin
            r_snz_cnt <= w_snz_nxt;
            if (w_snz_nxt >= SNZ_LIM) begin
              r_state    <= S_RING;
              r_ring_cnt <= 4'd0;
              r_phase    <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alarm_hh  = r_alarm_hh;
  assign alarm_mm  = r_alarm_mm;
  assign load_err  = r_load_err;
  assign ringing   = (r_state == S_RING);
  assign buzzer    = ringing & r_phase;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_time_of_day_keeper.sv
// Directed bench for time_of_day_keeper: rollover, loads, alarm ring/stop/timeout/snooze, async reset.
module tb_time_of_day_keeper;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0, one_minute = 1'b0;
  logic       load_time = 1'b0, load_alarm = 1'b0;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
  logic       alarm_en = 1'b0, stop_alarm = 1'b0, snooze = 1'b0;
  logic [7:0] time_hh, time_mm, alarm_hh, alarm_mm;
  logic       ringing, buzzer, load_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  time_of_day_keeper dut (
    .clock      (clock),
    .reset      (reset),
    .one_second (one_second),
    .one_minute (one_minute),
    .load_time  (load_time),
    .load_alarm (load_alarm),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .alarm_en   (alarm_en),
    .stop_alarm (stop_alarm),
    .snooze     (snooze),
    .time_hh    (time_hh),
    .time_mm    (time_mm),
    .alarm_hh   (alarm_hh),
    .alarm_mm   (alarm_mm),
    .ringing    (ringing),
    .buzzer     (buzzer),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Returns 1 time unit after the active edge so outputs are settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic minute();
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
  endtask

  task automatic second();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm);
    set_hh = hh; set_mm = mm; load_time = 1'b1;
    tick();
    load_time = 1'b0;
  endtask

  task automatic set_alarm(input logic [7:0] hh, input logic [7:0] mm);
    set_hh = hh; set_mm = mm; load_alarm = 1'b1;
    tick();
    load_alarm = 1'b0;
  endtask

  task automatic stop();
    stop_alarm = 1'b1;
    tick();
    stop_alarm = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [15:0] exp);
    check(tag, {16'h0, time_hh, time_mm}, {16'h0, exp});
  endtask

  initial begin
    repeat (3) tick();
    check("reset_ringing", ringing, 1'b0);
    reset = 1'b0;
    tick();
    check_time("reset_time", 16'h0000);
    check("reset_alarm", {alarm_hh, alarm_mm}, 16'h0000);
    check("reset_buzzer", buzzer, 1'b0);
    check("reset_load_err", load_err, 1'b0);
    check("reset_state", dbg_state, 2'd0);

    // rollover and carries
    set_time(8'h23, 8'h59);
    check_time("load_2359", 16'h2359);
    check("load_2359_err", load_err, 1'b0);
    minute();
    check_time("rollover", 16'h0000);
    check("rollover_err", load_err, 1'b0);
    set_time(8'h09, 8'h59);
    minute();
    check_time("hour_digit_carry", 16'h1000);
    set_time(8'h12, 8'h09);
    minute();
    check_time("minute_digit_carry", 16'h1210);

    // bad loads
    set_time(8'h24, 8'h00);
    check_time("bad_hh_time", 16'h1210);
    check("bad_hh_err", load_err, 1'b1);
    tick();
    check("bad_hh_err_pulse", load_err, 1'b0);
    set_time(8'h12, 8'h5A);
    check_time("bad_mm_time", 16'h1210);
    check("bad_mm_err", load_err, 1'b1);
    set_alarm(8'h1A, 8'h00);
    check("bad_alarm", {alarm_hh, alarm_mm}, 16'h0000);
    check("bad_alarm_err", load_err, 1'b1);

    // load_time beats one_minute
    one_minute = 1'b1;
    set_time(8'h10, 8'h30);
    one_minute = 1'b0;
    check_time("load_vs_minute", 16'h1030);

    // alarm fires on the minute edge
    set_alarm(8'h07, 8'h00);
    check("alarm_loaded", {alarm_hh, alarm_mm}, 16'h0700);
    alarm_en = 1'b1;
    set_time(8'h06, 8'h59);
    check("no_ring_before", ringing, 1'b0);
    minute();
    check("ring_same_edge", ringing, 1'b1);
    check("ring_state", dbg_state, 2'd1);
    check("buzz_entry", buzzer, 1'b1);
    second();
    check("buzz_toggle1", buzzer, 1'b0);
    second();
    check("buzz_toggle2", buzzer, 1'b1);

    // timeout after five minutes
    repeat (4) minute();
    check("ring_after_4min", ringing, 1'b1);
    minute();
    check("timeout_idle", ringing, 1'b0);
    check("timeout_buzzer", buzzer, 1'b0);
    check_time("timeout_time", 16'h0705);

    // stop_alarm
    set_time(8'h06, 8'h59);
    minute();
    check("ring_again", ringing, 1'b1);
    stop();
    check("stop_ringing", ringing, 1'b0);
    check("stop_buzzer", buzzer, 1'b0);

    // alarm_en drop ends ringing
    set_time(8'h06, 8'h59);
    minute();
    check("ring_en", ringing, 1'b1);
    alarm_en = 1'b0;
    tick();
    check("en_drop_idle", ringing, 1'b0);
    alarm_en = 1'b1;

    // loading an equal value is not a match
    set_time(8'h07, 8'h00);
    check("load_time_eq", ringing, 1'b0);
    set_alarm(8'h07, 8'h00);
    check("load_alarm_eq", ringing, 1'b0);

    // snooze
    set_time(8'h06, 8'h59);
    minute();
    check("ring_snz", ringing, 1'b1);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    check("snooze_silent", ringing, 1'b0);
    check("snooze_state", dbg_state, 2'd2);
    check("snooze_buzzer", buzzer, 1'b0);
    repeat (8) minute();
    check("snooze_8min", ringing, 1'b0);
    minute();
    check("snooze_rering", ringing, 1'b1);
    check("snooze_rering_buzz", buzzer, 1'b1);
    repeat (4) minute();
    check("rering_count_restart", ringing, 1'b1);
    stop_alarm = 1'b1; snooze = 1'b1;
    tick();
    stop_alarm = 1'b0; snooze = 1'b0;
    check("stop_beats_snooze", dbg_state, 2'd0);
`else
    check("snooze_ignored", ringing, 1'b1);
    check("snooze_ignored_state", dbg_state, 2'd1);
    stop();
    check("snooze_off_stop", ringing, 1'b0);
`endif

    // disarmed alarm does not fire
    alarm_en = 1'b0;
    set_time(8'h06, 8'h59);
    minute();
    check("disarmed_no_ring", ringing, 1'b0);

    // async reset mid-ring
    alarm_en = 1'b1;
    set_time(8'h06, 8'h59);
    minute();
    check("ring_pre_reset", ringing, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ringing", ringing, 1'b0);
    check("async_rst_buzzer", buzzer, 1'b0);
    check_time("async_rst_time", 16'h0000);
    check("async_rst_alarm", {alarm_hh, alarm_mm}, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_state", dbg_state, 2'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
